// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe computer mover: cell/winner codes,
// the eight-line table, the fallback pick lists and the FSM state type.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_PLYR  = 2'b01;
    localparam logic [1:0] CELL_COMP  = 2'b10;

    localparam logic [1:0] WIN_DRAW = 2'd0;
    localparam logic [1:0] WIN_PLYR = 2'd1;
    localparam logic [1:0] WIN_COMP = 2'd2;
    localparam logic [1:0] WIN_CONT = 2'd3;

    // Rows, then columns, then the two diagonals; scan order follows this table.
    localparam logic [3:0] LINE_CELLS [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [3:0] CENTRE_CELL      = 4'd4;
    localparam logic [3:0] CORNER_CELLS [4] = '{4'd0, 4'd2, 4'd6, 4'd8};
    localparam logic [3:0] SIDE_CELLS   [4] = '{4'd1, 4'd3, 4'd5, 4'd7};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_WIN,
        ST_SCAN_BLOCK,
        ST_PICK,
        ST_ISSUE
    } state_e;

endpackage

// File: rtl/ttt_computer_mover_if.sv
// Board-to-mover bundle: the core (master) drives board and status, the
// mover (slave) answers with a cell index and strobes.
interface ttt_computer_mover_if;

    logic [1:0] pos1;
    logic [1:0] pos2;
    logic [1:0] pos3;
    logic [1:0] pos4;
    logic [1:0] pos5;
    logic [1:0] pos6;
    logic [1:0] pos7;
    logic [1:0] pos8;
    logic [1:0] pos9;
    logic [1:0] winner;
    logic       move_req;
    logic [3:0] computer;
    logic       comp_play;
    logic       busy;
    logic       no_move;

    modport master (
        output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        output winner, move_req,
        input  computer, comp_play, busy, no_move
    );

    modport slave (
        input  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        input  winner, move_req,
        output computer, comp_play, busy, no_move
    );

endinterface

// File: rtl/ttt_line_eval.sv
// Evaluates one three-cell line: hit when exactly two cells carry the target
// code and the third is empty; slot names the empty position (0..2).
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] cellA_i,
    input  logic [1:0] cellB_i,
    input  logic [1:0] cellC_i,
    input  logic [1:0] target_i,
    output logic       hit_o,
    output logic [1:0] slot_o
);

    logic [1:0] targetCnt;
    logic [1:0] emptyCnt;

    always_comb begin
        targetCnt = {1'b0, cellA_i == target_i} + {1'b0, cellB_i == target_i}
                  + {1'b0, cellC_i == target_i};
        emptyCnt  = {1'b0, cellA_i == CELL_EMPTY} + {1'b0, cellB_i == CELL_EMPTY}
                  + {1'b0, cellC_i == CELL_EMPTY};
        slot_o = 2'd0;
        if (cellC_i == CELL_EMPTY) slot_o = 2'd2;
        if (cellB_i == CELL_EMPTY) slot_o = 2'd1;
        if (cellA_i == CELL_EMPTY) slot_o = 2'd0;
        hit_o = (targetCnt == 2'd2) && (emptyCnt == 2'd1);
    end

endmodule

// File: rtl/ttt_computer_mover.sv
// Computer move generator: snapshots the board on request, scans for a win,
// then a block, then falls back to centre/corner/side. Optional macro
// TTT_RANDOM_TIEBREAK_EN rotates the corner search start from an LFSR.
module ttt_computer_mover
    import ttt_pkg::*;
#(
    parameter int         PULSE_LEN = 1,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    ttt_computer_mover_if.slave  bus
);

    state_e     state_q, state_d;
    logic [2:0] lineCnt_q, lineCnt_d;
    logic [2:0] pulseCnt_q, pulseCnt_d;
    logic [3:0] computer_q, computer_d;
    logic       compPlay_q, compPlay_d;
    logic       busy_q, busy_d;
    logic       noMove_q, noMove_d;
    logic [1:0] board_q [9];
    logic [1:0] liveBoard [9];
    logic       capture;

    logic [1:0] lineTarget;
    logic       lineHit;
    logic [1:0] lineSlot;
    logic [3:0] hitCell;

    logic [1:0] cornerStart;
    logic [1:0] sweepIdx;
    logic       pickFound;
    logic [3:0] pickCell;

    assign liveBoard[0] = bus.pos1;
    assign liveBoard[1] = bus.pos2;
    assign liveBoard[2] = bus.pos3;
    assign liveBoard[3] = bus.pos4;
    assign liveBoard[4] = bus.pos5;
    assign liveBoard[5] = bus.pos6;
    assign liveBoard[6] = bus.pos7;
    assign liveBoard[7] = bus.pos8;
    assign liveBoard[8] = bus.pos9;

    assign bus.computer  = computer_q;
    assign bus.comp_play = compPlay_q;
    assign bus.busy      = busy_q;
    assign bus.no_move   = noMove_q;

`ifdef TTT_RANDOM_TIEBREAK_EN
    logic [7:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign cornerStart = lfsr_q[1:0];
`else
    assign cornerStart = 2'd0;
`endif

    assign lineTarget = (state_q == ST_SCAN_BLOCK) ? CELL_PLYR : CELL_COMP;

    ttt_line_eval u_lineEval (
        .cellA_i  (board_q[LINE_CELLS[lineCnt_q][0]]),
        .cellB_i  (board_q[LINE_CELLS[lineCnt_q][1]]),
        .cellC_i  (board_q[LINE_CELLS[lineCnt_q][2]]),
        .target_i (lineTarget),
        .hit_o    (lineHit),
        .slot_o   (lineSlot)
    );

    always_comb begin
        case (lineSlot)
            2'd1:    hitCell = LINE_CELLS[lineCnt_q][1];
            2'd2:    hitCell = LINE_CELLS[lineCnt_q][2];
            default: hitCell = LINE_CELLS[lineCnt_q][0];
        endcase
    end

    // Fallback choice: centre, then corners from cornerStart, then sides.
    always_comb begin
        pickFound = 1'b0;
        pickCell  = CENTRE_CELL;
        sweepIdx  = 2'd0;
        if (board_q[CENTRE_CELL] == CELL_EMPTY) pickFound = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sweepIdx = cornerStart + 2'(k);
            if (!pickFound && board_q[CORNER_CELLS[sweepIdx]] == CELL_EMPTY) begin
                pickFound = 1'b1;
                pickCell  = CORNER_CELLS[sweepIdx];
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (!pickFound && board_q[SIDE_CELLS[k]] == CELL_EMPTY) begin
                pickFound = 1'b1;
                pickCell  = SIDE_CELLS[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lineCnt_d  = lineCnt_q;
        pulseCnt_d = pulseCnt_q;
        computer_d = computer_q;
        compPlay_d = 1'b0;
        busy_d     = busy_q;
        noMove_d   = 1'b0;
        capture    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.move_req && bus.winner == WIN_CONT) begin
                    capture   = 1'b1;
                    lineCnt_d = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = ST_SCAN_WIN;
                end
            end
            ST_SCAN_WIN, ST_SCAN_BLOCK: begin
                if (lineHit) begin
                    computer_d = hitCell;
                    pulseCnt_d = 3'd0;
                    state_d    = ST_ISSUE;
                end else if (lineCnt_q == 3'd7) begin
                    lineCnt_d = 3'd0;
                    state_d   = (state_q == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_PICK;
                end else begin
                    lineCnt_d = lineCnt_q + 3'd1;
                end
            end
            ST_PICK: begin
                if (pickFound) begin
                    computer_d = pickCell;
                    pulseCnt_d = 3'd0;
                    state_d    = ST_ISSUE;
                end else begin
                    noMove_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (pulseCnt_q < 3'(PULSE_LEN)) begin
                    compPlay_d = 1'b1;
                    pulseCnt_d = pulseCnt_q + 3'd1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lineCnt_q  <= 3'd0;
            pulseCnt_q <= 3'd0;
            computer_q <= 4'd0;
            compPlay_q <= 1'b0;
            busy_q     <= 1'b0;
            noMove_q   <= 1'b0;
            for (int i = 0; i < 9; i++) board_q[i] <= CELL_EMPTY;
        end else begin
            state_q    <= state_d;
            lineCnt_q  <= lineCnt_d;
            pulseCnt_q <= pulseCnt_d;
            computer_q <= computer_d;
            compPlay_q <= compPlay_d;
            busy_q     <= busy_d;
            noMove_q   <= noMove_d;
            if (capture) begin
                for (int i = 0; i < 9; i++) board_q[i] <= liveBoard[i];
            end
        end
    end

endmodule

// File: doc/ttt_computer_mover.md
Name: ttt_computer_mover

Overview:
- Computer-side move generator for the tic-tac-toe game core, i.e. the producer of the `computer`/`comp_play` move interface that the core consumes.
- On `move_req` it snapshots the nine board cells and the game status, then scans the eight lines sequentially.
- It issues one legal move using the fixed priority: win, block, centre, corner, side.
- It sits between the board outputs (pos1..pos9, winner) and the core's computer-move inputs.

Parameters:
- PULSE_LEN, 1: number of cycles `comp_play` stays high per issued move (1..4).
- LFSR_SEED, 8'hA5: reset seed of the tiebreak LFSR. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pos1..pos9  in  2 each  board cells: 00 empty, 01 player, 10 computer, 11 treated as occupied
- winner  in  2  game status: 0 draw, 1 player, 2 computer, 3 continuing
- move_req  in  1  level/pulse; computer's turn requested
- computer  out  4  chosen cell index 0..8 (pos1 = 0 ... pos9 = 8)
- comp_play  out  1  move strobe, high PULSE_LEN cycles
- busy  out  1  high from request acceptance to end of the strobe
- no_move  out  1  1-cycle pulse: request accepted but board has no empty cell

Behaviour:
- Reset (async): FSM to IDLE; computer=0; comp_play=0; busy=0; no_move=0; line counter=0; LFSR=LFSR_SEED.
- FSM states: IDLE, SCAN_WIN, SCAN_BLOCK, PICK, ISSUE.
- IDLE:
  - Accept when move_req=1 and winner==3. On acceptance (cycle 0): latch snapshot of pos1..pos9, line counter=0, busy=1, go to SCAN_WIN.
  - move_req while winner!=3 is ignored.
  - move_req while busy is ignored; no queueing.
- Line order:
  - 0 = (0,1,2), 1 = (3,4,5), 2 = (6,7,8)
  - 3 = (0,3,6), 4 = (1,4,7), 5 = (2,5,8)
  - 6 = (0,4,8), 7 = (2,4,6)
- SCAN_WIN:
  - One line per cycle. Hit = exactly two cells 10 and one cell 00.
  - On hit: latch the empty cell index, go to ISSUE.
  - After line 7 with no hit: counter=0, go to SCAN_BLOCK.
- SCAN_BLOCK: same as SCAN_WIN with the hit defined as two cells 01 and one cell 00. After line 7 with no hit, go to PICK.
- PICK (one cycle): select the first empty cell in order 4; 0,2,6,8; 1,3,5,7.
  - If no cell is empty: pulse no_move for one cycle, drop busy, return to IDLE; comp_play stays 0.
- ISSUE:
  - computer holds the index; comp_play=1 for PULSE_LEN cycles.
  - Then comp_play=0 and busy=0, return to IDLE.
  - computer retains its last value until the next issue.
- Latency from the acceptance edge (PULSE_LEN=1) to first comp_play=1:
  - win hit on line L: L+2
  - block hit on line L: L+10
  - fallback: 18
  - no_move appears at cycle 17.
- Snapshot: the scan uses only latched cells. Live board changes during a scan have no effect. winner is checked only at acceptance.
- Simultaneous win and block availability: win always takes precedence. Within a phase, the lowest-numbered line wins.
- Reset mid-operation: immediate return to IDLE, strobe aborted, no partial move issued.

Optional Feature:
- Macro TTT_RANDOM_TIEBREAK_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle.
  - In PICK, the corner search starts at corner LFSR[1:0] of list (0,2,6,8) and rotates.
  - Centre and side order are unchanged.
- Undefined: no LFSR logic; the corner order is fixed as 0,2,6,8.

Decomposition:
- Shared package ttt_pkg:
  - cell codes CELL_EMPTY/CELL_PLYR/CELL_COMP
  - winner codes WIN_DRAW/WIN_PLYR/WIN_COMP/WIN_CONT
  - line table constant LINE_CELLS[8][3] (4-bit indices)
  - FSM state enum
- Sub-module ttt_line_eval: combinational. Inputs: three 2-bit cells, 2-bit target code. Outputs: hit flag and 2-bit slot of the empty cell.

Test Plan:
- Win: pos1=pos2=10, pos4=pos5=01, rest 00, req -> computer=2, comp_play high at cycle 2 only.
- Block: pos1=pos5=01, pos2=10, rest 00 -> computer=8 (line 6), comp_play at cycle 16.
- Precedence: pos7=pos8=10 plus pos1=pos2=01 -> computer=8 via win (line 2) at cycle 4, not the block at 2.
- Empty board -> computer=4 at cycle 18. With pos5=01 only and the feature off -> computer=0 at cycle 18.
- Full board, winner=3 -> no_move pulse at cycle 17, comp_play never high. Same board with winner=0 -> request ignored, busy stays 0.
- Assert reset at cycle 9 of a fallback scan -> all outputs 0 in the same cycle. Re-request after release -> normal 18-cycle result.
